// File: rtl/vec_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vec_pkg : shared opcodes, FSM states and defaults for the vector |
// | execution unit.                                  Revision: 1.0   |
// +------------------------------------------------------------------+
package vec_pkg;

    localparam int LANES_DEF = 16;
    localparam int W_DEF     = 32;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_MUL    = 4'd2,
        OP_AND    = 4'd3,
        OP_OR     = 4'd4,
        OP_XOR    = 4'd5,
        OP_SLL    = 4'd6,
        OP_SRL    = 4'd7,
        OP_SRA    = 4'd8,
        OP_MOVB   = 4'd9,
        OP_REDSUM = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_HOLD   = 2'd2
    } state_e;

    // Codes above REDSUM are reserved and reported through err.
    function automatic logic op_legal(input logic [3:0] op);
        return (op <= 4'd10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_exec_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vector_exec_unit_if : issue and register-file write bundle.      |
// |                                                  Revision: 1.0   |
// +------------------------------------------------------------------+
interface vector_exec_unit_if
    import vec_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int W     = W_DEF
);
    logic                        in_valid;
    logic                        in_ready;
    logic [3:0]                  op;
    logic                        is_vec;
    logic [3:0]                  dest;
    logic [LANES-1:0][W-1:0]     src_a;
    logic [LANES-1:0][W-1:0]     src_b;
    logic                        out_valid;
    logic                        out_ready;
    logic                        we;
    logic [3:0]                  wa;
    logic [LANES-1:0][W-1:0]     wd;
    logic                        wsel_vec;
    logic                        err;

    modport master (
        output in_valid, op, is_vec, dest, src_a, src_b, out_ready,
        input  in_ready, out_valid, we, wa, wd, wsel_vec, err
    );

    modport slave (
        input  in_valid, op, is_vec, dest, src_a, src_b, out_ready,
        output in_ready, out_valid, we, wa, wd, wsel_vec, err
    );
endinterface
`default_nettype wire

// File: rtl/vec_lane_alu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vec_lane_alu : combinational single-lane arithmetic.             |
// |                                                  Revision: 1.0   |
// +------------------------------------------------------------------+
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [3:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    logic [4:0] w_sh;
    assign w_sh = b_i[4:0];

    // REDSUM and reserved codes yield zero; the reduction path lives in the top.
    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_MUL:  y_o = a_i * b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_SLL:  y_o = a_i << w_sh;
            OP_SRL:  y_o = a_i >> w_sh;
            OP_SRA:  y_o = W'($signed(a_i) >>> w_sh);
            OP_MOVB: y_o = b_i;
            default: y_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vector_exec_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vector_exec_unit : lane-wise vector/scalar ALU with a 4-cycle    |
// | REDSUM reduction and a held write-back handshake. Revision: 1.0  |
// +------------------------------------------------------------------+
module vector_exec_unit
    import vec_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int W     = W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    vector_exec_unit_if.slave  bus
);

    localparam int RED_STEPS = LANES / 4;
    localparam int CW        = (RED_STEPS > 1) ? $clog2(RED_STEPS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RED_STEPS - 1);

    typedef logic [LANES-1:0][W-1:0] vec_t;

    state_e        state_q;
    logic          out_valid_q;
    logic          wsel_q;
    logic          err_q;
    logic [3:0]    wa_q;
    vec_t          wd_q;
    vec_t          red_q;
    logic [W-1:0]  acc_q;
    logic [CW-1:0] cnt_q;

    vec_t          lane_d;
    vec_t          red_wd_d;
    logic [W-1:0]  acc_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [W-1:0] y;
        vec_lane_alu #(.W(W)) u_alu (
            .op_i (bus.op),
            .a_i  (bus.src_a[i]),
            .b_i  (bus.src_b[i]),
            .y_o  (y)
        );
        if (i == LANES - 1) begin : g_scalar_lane
            assign lane_d[i] = y;
        end else begin : g_vec_lane
            assign lane_d[i] = bus.is_vec ? y : '0;
        end
    end

    // red_q shifts down four lanes per step, so lanes 0-3 always hold the next group.
    assign acc_d = acc_q + red_q[0] + red_q[1] + red_q[2] + red_q[3];

    always_comb begin
        red_wd_d            = '0;
        red_wd_d[LANES-1]   = acc_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            wsel_q      <= 1'b0;
            err_q       <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
            red_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        wa_q <= bus.dest;
                        if (bus.op == OP_REDSUM) begin
                            red_q   <= bus.src_a;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_REDUCE;
                        end else begin
                            wd_q        <= lane_d;
                            wsel_q      <= bus.is_vec;
                            err_q       <= ~op_legal(bus.op);
                            out_valid_q <= 1'b1;
                            state_q     <= S_HOLD;
                        end
                    end
                end
                S_REDUCE: begin
                    acc_q <= acc_d;
                    red_q <= red_q >> (4 * W);
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        wd_q        <= red_wd_d;
                        wsel_q      <= 1'b0;
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.we        = out_valid_q & bus.out_ready;
    assign bus.wa        = wa_q;
    assign bus.wd        = wd_q;
    assign bus.wsel_vec  = wsel_q;
    assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_exec_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vector_exec_unit : scoreboard bench for vector_exec_unit.     |
// |                                                  Revision: 1.0   |
// +------------------------------------------------------------------+
module tb_vector_exec_unit;
    import vec_pkg::*;

    localparam int L  = 16;
    localparam int WW = 32;

    typedef logic [L-1:0][WW-1:0] vec_t;
    typedef struct {
        logic [3:0] wa;
        vec_t       wd;
        logic       wsel;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   we_count = 0;
    exp_t sb[$];

    vector_exec_unit_if #(.LANES(L), .W(WW)) bus ();

    vector_exec_unit #(.LANES(L), .W(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.we === 1'b1) we_count++;

    function automatic logic [WW-1:0] lane_fn(input logic [3:0] op, input logic [WW-1:0] a, input logic [WW-1:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a * b;
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return a ^ b;
            4'd6: return a << s;
            4'd7: return a >> s;
            4'd8: return WW'($signed(a) >>> s);
            4'd9: return b;
            default: return '0;
        endcase
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic v, input logic [3:0] d, input vec_t a, input vec_t b);
        exp_t e;
        logic [WW-1:0] sum;
        e.wa = d; e.wd = '0; e.wsel = v; e.err = 1'b0;
        if (op == 4'd10) begin
            sum = '0;
            for (int l = 0; l < L; l++) sum = sum + a[l];
            e.wd[L-1] = sum;
            e.wsel    = 1'b0;
        end else if (op > 4'd10) begin
            e.err = 1'b1;
        end else begin
            for (int l = 0; l < L; l++)
                if (v || l == L - 1) e.wd[l] = lane_fn(op, a[l], b[l]);
        end
        return e;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int l = 0; l < L; l++) r[l] = $urandom;
        return r;
    endfunction

    task automatic send(input logic [3:0] op, input logic v, input logic [3:0] d,
                        input vec_t a, input vec_t b, input string name);
        @(negedge clk);
        bus.op = op; bus.is_vec = v; bus.dest = d;
        bus.src_a = a; bus.src_b = b; bus.in_valid = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_issue in_ready got=%b exp=1", name, bus.in_ready);
        end
        sb.push_back(model(op, v, d, a, b));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.src_a = rand_vec();
        bus.src_b = rand_vec();
    endtask

    task automatic recv(input string name, input int exp_lat, input int stall);
        int   n;
        logic ir_bad;
        exp_t e;
        int   wc0;
        n = 0; ir_bad = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (bus.in_ready !== 1'b0) ir_bad = 1'b1;
        end while (bus.out_valid !== 1'b1 && n < 20);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout out_valid got=%b exp=1", name, bus.out_valid);
            sb.delete();
            return;
        end
        if (exp_lat > 0) begin
            checks++;
            if (n != exp_lat) begin
                failures++;
                $display("FAIL %s_latency got=%0d exp=%0d", name, n, exp_lat);
            end
        end
        checks++;
        if (ir_bad) begin
            failures++;
            $display("FAIL %s_busy in_ready got=1 exp=0 while busy", name);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_scoreboard got=empty exp=entry", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (bus.wa !== e.wa || bus.wd !== e.wd || bus.wsel_vec !== e.wsel || bus.err !== e.err) begin
            failures++;
            $display("FAIL %s_result got wa=%h wsel=%b err=%b wd=%h exp wa=%h wsel=%b err=%b wd=%h",
                     name, bus.wa, bus.wsel_vec, bus.err, bus.wd, e.wa, e.wsel, e.err, e.wd);
        end
        wc0 = we_count;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.we !== 1'b0 ||
                bus.wa !== e.wa || bus.wd !== e.wd || bus.wsel_vec !== e.wsel || bus.err !== e.err) begin
                failures++;
                $display("FAIL %s_stall%0d got ov=%b ir=%b we=%b wa=%h exp ov=1 ir=0 we=0 wa=%h (held)",
                         name, k, bus.out_valid, bus.in_ready, bus.we, bus.wa, e.wa);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.we !== 1'b1) begin
            failures++;
            $display("FAIL %s_we got=%b exp=1", name, bus.we);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        checks++;
        if (we_count - wc0 != 1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_release got we_pulses=%0d ov=%b ir=%b exp we_pulses=1 ov=0 ir=1",
                     name, we_count - wc0, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.is_vec = 1'b0;
        bus.dest = '0; bus.src_a = '0; bus.src_b = '0;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.we !== 1'b0 || bus.err !== 1'b0 || bus.wa !== 4'd0 ||
            bus.wd !== '0 || bus.wsel_vec !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset got ov=%b we=%b err=%b wa=%h wsel=%b ir=%b exp all zero ir=1",
                     bus.out_valid, bus.we, bus.err, bus.wa, bus.wsel_vec, bus.in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_add_vec();
        vec_t a, b;
        for (int l = 0; l < L; l++) begin a[l] = WW'(l); b[l] = 32'd1; end
        send(4'd0, 1'b1, 4'd3, a, b, "add_vec");
        recv("add_vec", 1, 0);
    endtask

    task automatic test_mul_scalar();
        vec_t a, b;
        a = '1; b = '1;
        a[L-1] = 32'd4; b[L-1] = 32'd5;
        send(4'd2, 1'b0, 4'd7, a, b, "mul_scalar");
        recv("mul_scalar", 1, 0);
    endtask

    task automatic test_redsum();
        vec_t a, b;
        logic [WW-1:0] vals [L];
        vals = '{1, 6, 7, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 3, 4, 5};
        for (int l = 0; l < L; l++) a[l] = vals[l];
        b = rand_vec();
        send(4'd10, 1'b1, 4'd9, a, b, "redsum");
        recv("redsum", 5, 0);
    endtask

    task automatic test_hold_stall();
        send(4'd5, 1'b1, 4'd12, rand_vec(), rand_vec(), "hold_stall");
        // Competing request while busy must be ignored.
        bus.in_valid = 1'b1; bus.op = 4'd0; bus.dest = 4'd1;
        recv("hold_stall", 1, 3);
    endtask

    task automatic test_reset_in_reduce();
        int wc0;
        send(4'd10, 1'b0, 4'd5, rand_vec(), rand_vec(), "rst_reduce");
        @(negedge clk);
        @(negedge clk);
        wc0 = we_count;
        bus.out_ready = 1'b1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.we !== 1'b0 || bus.wd !== '0 || bus.wa !== 4'd0 ||
            bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_reduce_clear got ov=%b we=%b wa=%h err=%b ir=%b exp zeros ir=1",
                     bus.out_valid, bus.we, bus.wa, bus.err, bus.in_ready);
        end
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || we_count != wc0) begin
            failures++;
            $display("FAIL rst_reduce_after got ir=%b we_pulses=%0d exp ir=1 we_pulses=0",
                     bus.in_ready, we_count - wc0);
        end
        bus.out_ready = 1'b0;
        send(4'd12, 1'b1, 4'd2, rand_vec(), rand_vec(), "illegal");
        recv("illegal", 1, 0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        for (int t = 0; t < 12; t++) begin
            op = 4'($urandom_range(0, 15));
            send(op, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_vec(), rand_vec(), "b2b");
            recv("b2b", (op == 4'd10) ? 5 : 1, t % 2);
        end
    endtask

    task automatic test_shifts();
        vec_t a, b;
        for (int l = 0; l < L; l++) begin a[l] = 32'h8000_00F0 ^ WW'(l); b[l] = 32'hFFFF_FFE0 | WW'(l); end
        for (int o = 6; o <= 8; o++) begin
            send(4'(o), 1'b1, 4'(o), a, b, "shift");
            recv("shift", 1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_add_vec();
        test_mul_scalar();
        test_redsum();
        test_hold_stall();
        test_reset_in_reduce();
        test_shifts();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vector_exec_unit.md
VECTOR_EXEC_UNIT -- requirements
Module: vector_exec_unit

Interface
REQ-001 Parameter LANES, default 16, is the number of vector lanes; lane 15 carries the scalar operand or result.
REQ-002 Parameter W, default 32, is the lane width in bits.
REQ-003 Port clk, input, 1, is the single clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1, is the asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, means an operation is presented.
REQ-006 Port in_ready, output, 1, means the unit accepts the operation this cycle.
REQ-007 Port op, input, 4, is the opcode, encoded per the shared package.
REQ-008 Port is_vec, input, 1, selects mode: 1 = vector operation, 0 = scalar operation.
REQ-009 Port dest, input, 4, is the destination register index.
REQ-010 Port src_a, input, LANES x W, is operand A, taken from register-file read port 1.
REQ-011 Port src_b, input, LANES x W, is operand B, taken from register-file read port 2.
REQ-012 Port out_valid, output, 1, means a result is held on the write outputs.
REQ-013 Port out_ready, input, 1, means the consumer takes the result.
REQ-014 Port we, output, 1, is the register-file write strobe and equals out_valid AND out_ready.
REQ-015 Port wa, output, 4, is the write address (latched dest).
REQ-016 Port wd, output, LANES x W, is the write data.
REQ-017 Port wsel_vec, output, 1, is the write mode: 1 = vector write, 0 = scalar write from wd lane 15.
REQ-018 Port err, output, 1, flags an illegal opcode for the held result.

Function
REQ-019 Opcodes SHALL be ADD=0, SUB=1, MUL=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, MOVB=9, REDSUM=10; codes 11-15 are illegal.
REQ-020 Lane-wise ops SHALL compute each lane independently, truncated to W bits; MUL keeps the low W bits of the unsigned product.
REQ-021 Shifts SHALL use bits [4:0] of the same lane of src_b as the shift amount.
REQ-022 In scalar mode the unit SHALL compute lane 15 only and drive lanes 14:0 of wd to zero; wsel_vec SHALL equal is_vec.
REQ-023 The FSM SHALL have the states IDLE, REDUCE and HOLD.
REQ-024 IDLE: in_ready=1; a transfer (in_valid and in_ready) of a lane-wise op SHALL register the result and move to HOLD, giving 1-cycle latency.
REQ-025 A transfer of REDSUM SHALL latch src_a, clear the accumulator and move to REDUCE.
REQ-026 REDUCE SHALL add 4 lanes per cycle, lanes 0-3 first, over exactly 4 cycles, then move to HOLD.
REQ-027 The REDSUM result SHALL be the modulo-2^W sum in wd lane 15, with lanes 14:0 zero, wsel_vec=0 and is_vec ignored.
REQ-028 HOLD: out_valid=1, and wa, wd, wsel_vec and err SHALL be stable until out_ready.
REQ-029 In HOLD, out_ready=1 SHALL return the FSM to IDLE on the next edge.
REQ-030 in_ready SHALL be 0 in REDUCE and in HOLD; the unit has no skid buffer and no back-to-back overlap.
REQ-031 An illegal opcode SHALL produce wd=0 and err=1, and SHALL complete through HOLD like a lane-wise op.
REQ-032 in_valid SHALL be ignored while in_ready=0, and operands SHALL NOT be sampled outside a transfer.

Reset
REQ-033 When rst is low, asynchronously: state=IDLE, out_valid=0, we=0, err=0, wa=0, wd=0, wsel_vec=0, accumulator=0 and the lane counter=0.
REQ-034 A reset during REDUCE or HOLD SHALL discard the operation with no write strobe; in_ready=1 on the first edge after release.

Structure
REQ-035 The opcode enum, the LANES/W defaults and the state enum SHALL live in a shared package, vec_pkg.
REQ-036 Lane arithmetic SHALL be a sub-module, vec_lane_alu (one lane, combinational), instantiated LANES times.

Verification
REQ-037 Reset release, then ADD vector with src_a lane i = i and src_b lane i = 1, dest=3 -> one cycle later out_valid=1, wd lane i = i+1, wa=3, wsel_vec=1.
REQ-038 Scalar MUL with lane15 a=4 and b=5, the other lanes set to 0xFFFFFFFF -> wd lane 15 = 20, lanes 14:0 = 0, wsel_vec=0.
REQ-039 REDSUM with src_a lanes = {1,6,7,1,1,2,0,0,0,0,0,0,0,3,4,5} -> out_valid on the 5th cycle after the transfer, wd lane 15 = 30, in_ready=0 throughout.
REQ-040 HOLD with out_ready=0 for 3 cycles, then 1 -> outputs stable, we pulses exactly once, in_ready=1 the next cycle.
REQ-041 rst asserted during the 2nd REDUCE cycle -> outputs zero immediately, no we pulse; op=12 afterwards -> err=1, wd=0.
